// File: rtl/rt_pkg.sv
// Shared types and constants for the RT JTAG debug transport.
package rt_pkg;

  localparam logic [31:0] DbgIdCode = 32'h1000_0DB3;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_e;

  typedef enum logic [4:0] {
    IR_IDCODE = 5'h01,
    IR_DTMCS  = 5'h10,
    IR_DMI    = 5'h11,
    IR_BYPASS = 5'h1f
  } jtag_ir_e;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  localparam logic [1:0] DMI_OP_NOP      = 2'd0;
  localparam logic [1:0] DMI_OP_READ     = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE    = 2'd2;

  localparam logic [1:0] DMI_STAT_OK     = 2'd0;
  localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
  localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

endpackage

// File: rtl/rt_jtag_tap.sv
// IEEE 1149.1 TAP controller with instruction register and per-register DR strobes.
module rt_jtag_tap import rt_pkg::*; #(
  parameter int unsigned IrLength = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic [IrLength-1:0] ir_o,
  output logic                ir_tdo_o,
  output logic                shift_ir_o,
  output logic                shift_dr_o,
  output logic                idcode_capture_o,
  output logic                bypass_capture_o,
  output logic                dtmcs_capture_o,
  output logic                dmi_capture_o,
  output logic                dtmcs_update_o,
  output logic                dmi_update_o
);

  tap_state_e          state_q, state_d;
  logic [IrLength-1:0] ir_q, ir_sr_q;
  logic                sel_idcode, sel_dtmcs, sel_dmi, sel_bypass;

  assign sel_idcode = (ir_q == IrLength'(IR_IDCODE));
  assign sel_dtmcs  = (ir_q == IrLength'(IR_DTMCS));
  assign sel_dmi    = (ir_q == IrLength'(IR_DMI));
  assign sel_bypass = !(sel_idcode || sel_dtmcs || sel_dmi);

  // TAP state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= TEST_LOGIC_RESET;
    else         state_q <= state_d;
  end

  // Standard TMS-driven transitions and state-decoded strobes
  always_comb begin
    state_d          = state_q;
    shift_ir_o       = 1'b0;
    shift_dr_o       = 1'b0;
    idcode_capture_o = 1'b0;
    bypass_capture_o = 1'b0;
    dtmcs_capture_o  = 1'b0;
    dmi_capture_o    = 1'b0;
    dtmcs_update_o   = 1'b0;
    dmi_update_o     = 1'b0;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = tms_i ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR: begin
        state_d          = tms_i ? EXIT1_DR : SHIFT_DR;
        idcode_capture_o = sel_idcode;
        bypass_capture_o = sel_bypass;
        dtmcs_capture_o  = sel_dtmcs;
        dmi_capture_o    = sel_dmi;
      end
      SHIFT_DR: begin
        state_d    = tms_i ? EXIT1_DR : SHIFT_DR;
        shift_dr_o = 1'b1;
      end
      EXIT1_DR:         state_d = tms_i ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_d = tms_i ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         state_d = tms_i ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: begin
        state_d        = tms_i ? SELECT_DR_SCAN : RUN_TEST_IDLE;
        dtmcs_update_o = sel_dtmcs;
        dmi_update_o   = sel_dmi;
      end
      SELECT_IR_SCAN:   state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: begin
        state_d    = tms_i ? EXIT1_IR : SHIFT_IR;
        shift_ir_o = 1'b1;
      end
      EXIT1_IR:         state_d = tms_i ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_d = tms_i ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         state_d = tms_i ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_d = tms_i ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // Instruction register: capture, LSB-first shift, update; IDCODE in reset state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ir_q    <= IrLength'(IR_IDCODE);
      ir_sr_q <= '0;
    end else begin
      case (state_q)
        TEST_LOGIC_RESET: ir_q    <= IrLength'(IR_IDCODE);
        CAPTURE_IR:       ir_sr_q <= IrLength'(1);
        SHIFT_IR:         ir_sr_q <= {tdi_i, ir_sr_q[IrLength-1:1]};
        UPDATE_IR:        ir_q    <= ir_sr_q;
        default:          ;
      endcase
    end
  end

  assign ir_o     = ir_q;
  assign ir_tdo_o = ir_sr_q[0];

endmodule

// File: rtl/rt_jtag_dtm.sv
// JTAG debug transport: DR shift registers, DTMCS status and DMI request/response bridge.
module rt_jtag_dtm import rt_pkg::*; #(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = DbgIdCode,
  parameter int unsigned AddrWidth   = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tms_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  output logic                 tdo_oe_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [1:0]           dmi_req_op_o,
  output logic [31:0]          dmi_req_data_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_resp_i
);

  localparam int unsigned DrW = AddrWidth + 34;

  logic [IrLength-1:0]  ir;
  logic                 ir_tdo, shift_ir, shift_dr;
  logic                 idcode_cap, bypass_cap, dtmcs_cap, dmi_cap, dtmcs_upd, dmi_upd;
  logic                 ir_is_dmi, ir_is_32;
  logic [DrW-1:0]       dr_q;
  logic [AddrWidth-1:0] dr_addr;
  logic [31:0]          dr_data;
  logic [1:0]           dr_op;

  logic [1:0]           sticky_q, sticky_d, dmi_stat;
  logic                 outst_q, req_vld_q, acc_q, disc_q;
  logic [AddrWidth-1:0] addr_q;
  dmi_req_t             req_q;
  logic [31:0]          resp_data_q;
  dmi_resp_t            resp_in;
  dtmcs_t               dtmcs_val;
  logic                 req_fire, resp_fire, discard, hard_rst, soft_rst, start, capture_busy;

  rt_jtag_tap #(.IrLength(IrLength)) u_tap (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .tms_i            (tms_i),
    .tdi_i            (tdi_i),
    .ir_o             (ir),
    .ir_tdo_o         (ir_tdo),
    .shift_ir_o       (shift_ir),
    .shift_dr_o       (shift_dr),
    .idcode_capture_o (idcode_cap),
    .bypass_capture_o (bypass_cap),
    .dtmcs_capture_o  (dtmcs_cap),
    .dmi_capture_o    (dmi_cap),
    .dtmcs_update_o   (dtmcs_upd),
    .dmi_update_o     (dmi_upd)
  );

  // Shift length follows the selected register; unknown codes behave as BYPASS
  assign ir_is_dmi = (ir == IrLength'(IR_DMI));
  assign ir_is_32  = (ir == IrLength'(IR_IDCODE)) || (ir == IrLength'(IR_DTMCS));

  assign dr_addr = dr_q[DrW-1:34];
  assign dr_data = dr_q[33:2];
  assign dr_op   = dr_q[1:0];
  assign resp_in = {dmi_resp_data_i, dmi_resp_resp_i};

  // Captured DTMCS image and DMI scan status (sticky first, then busy)
  always_comb begin
    dtmcs_val         = '0;
    dtmcs_val.version = 4'd1;
    dtmcs_val.abits   = 6'(AddrWidth);
    dtmcs_val.dmistat = sticky_q;
    dtmcs_val.idle    = 3'd1;
    if (sticky_q != DMI_STAT_OK) dmi_stat = sticky_q;
    else if (outst_q)            dmi_stat = DMI_STAT_BUSY;
    else                         dmi_stat = DMI_STAT_OK;
  end

  // Shared DR shift register; new bits enter at the MSB of the selected length
  always_ff @(posedge clk_i) begin
    if (idcode_cap)      dr_q <= DrW'(IdcodeValue);
    else if (dtmcs_cap)  dr_q <= DrW'(dtmcs_val);
    else if (dmi_cap)    dr_q <= {addr_q, resp_data_q, dmi_stat};
    else if (bypass_cap) dr_q <= '0;
    else if (shift_dr) begin
      if (ir_is_dmi)     dr_q <= {tdi_i, dr_q[DrW-1:1]};
      else if (ir_is_32) dr_q <= {{(DrW-32){1'b0}}, tdi_i, dr_q[31:1]};
      else               dr_q <= {{(DrW-1){1'b0}}, tdi_i};
    end
  end

  // TDO launches on the falling edge so the debugger samples it on the next rising edge
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_oe_o <= shift_ir || shift_dr;
      if (shift_ir)      tdo_o <= ir_tdo;
      else if (shift_dr) tdo_o <= dr_q[0];
      else               tdo_o <= 1'b0;
    end
  end

  assign req_fire     = req_vld_q && dmi_req_ready_i;
  assign resp_fire    = acc_q && dmi_resp_valid_i;
  assign hard_rst     = dtmcs_upd && dr_q[17];
  assign soft_rst     = dtmcs_upd && dr_q[16];
  assign discard      = disc_q || hard_rst;
  assign start        = dmi_upd && (dr_op == DMI_OP_READ || dr_op == DMI_OP_WRITE) &&
                        (sticky_q == DMI_STAT_OK) && !outst_q && !acc_q;
  assign capture_busy = dmi_cap && (sticky_q == DMI_STAT_OK) && outst_q;

  // Sticky status: clears, then busy-on-capture, then a failed response
  always_comb begin
    sticky_d = sticky_q;
    if (soft_rst || hard_rst) sticky_d = DMI_STAT_OK;
    if (capture_busy)         sticky_d = DMI_STAT_BUSY;
    if (resp_fire && !discard && (resp_in.resp != 2'd0)) sticky_d = DMI_STAT_FAILED;
  end

  // DMI transaction tracking; a response after a hard reset is drained and dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q    <= DMI_STAT_OK;
      outst_q     <= 1'b0;
      req_vld_q   <= 1'b0;
      acc_q       <= 1'b0;
      disc_q      <= 1'b0;
      addr_q      <= '0;
      req_q       <= '0;
      resp_data_q <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (start) begin
        outst_q   <= 1'b1;
        req_vld_q <= 1'b1;
        addr_q    <= dr_addr;
        req_q     <= '{data: dr_data, op: dr_op};
      end else if (hard_rst) begin
        outst_q   <= 1'b0;
        req_vld_q <= 1'b0;
      end else begin
        if (req_fire)              req_vld_q <= 1'b0;
        if (resp_fire && !discard) outst_q   <= 1'b0;
      end
      if (req_fire)       acc_q <= 1'b1;
      else if (resp_fire) acc_q <= 1'b0;
      if (resp_fire)                           disc_q <= 1'b0;
      else if (hard_rst && (acc_q || req_fire)) disc_q <= 1'b1;
      if (resp_fire && !discard) resp_data_q <= resp_in.data;
    end
  end

  assign dmi_req_valid_o  = req_vld_q;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_op_o     = req_q.op;
  assign dmi_req_data_o   = req_q.data;
  assign dmi_resp_ready_o = acc_q;

endmodule
